// File: rtl/approx_product_expander.sv
`default_nettype none
// ============================================================================
// Module      : approx_product_expander
// Description : Back-end of the approximate multiplier. Rebuilds the 32-bit
//               product by shifting the mantissa left (MANT_W - shamt) places.
//               Optional macro EXPANDER_DUAL_SHIFT_EN shifts two places/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_product_expander #(
    parameter int MANT_W = 16,
    parameter int SH_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-1:0]     mant,
    input  logic [SH_W-1:0]       shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   result
);

    localparam logic [SH_W-1:0] c_mant_w = SH_W'(MANT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [2*MANT_W-1:0]   r_result;
    logic [SH_W-1:0]       r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic [SH_W-1:0]       w_shamt_clamped;
    logic [SH_W-1:0]       w_k;
    logic                  w_skip_shift;

    // Shift counts beyond the mantissa width all collapse to "no shift".
    assign w_shamt_clamped = (shamt > c_mant_w) ? c_mant_w : shamt;
    assign w_k             = c_mant_w - w_shamt_clamped;
    assign w_skip_shift    = (w_k == '0) || (mant == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_result   <= {{MANT_W{1'b0}}, mant};
                        r_count    <= w_k;
                        r_in_ready <= 1'b0;
                        if (w_skip_shift) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
`ifdef EXPANDER_DUAL_SHIFT_EN
                    if (r_count >= SH_W'(2)) begin
                        r_result <= r_result << 2;
                        r_count  <= r_count - SH_W'(2);
                        if (r_count == SH_W'(2)) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_result    <= r_result << 1;
                        r_count     <= r_count - SH_W'(1);
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
`else
                    r_result <= r_result << 1;
                    r_count  <= r_count - SH_W'(1);
                    // The final position is shifted on the same edge we leave.
                    if (r_count == SH_W'(1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_approx_product_expander.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_product_expander
// Description : Directed self-checking bench for approx_product_expander.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_approx_product_expander;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mant;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int tests;
    int fails;

    approx_product_expander #(.MANT_W(16), .SH_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant      (mant),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input int k);
`ifdef EXPANDER_DUAL_SHIFT_EN
        return (k + 1) / 2 + 1;
`else
        return k + 1;
`endif
    endfunction

    // Present one input and return on the accept edge (+1 time unit).
    task automatic accept(input logic [15:0] m, input logic [4:0] s);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        mant = m; shamt = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mant = 16'hDEAD; shamt = 5'd7;
    endtask

    // Cycles from the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++;
        if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h exp=00000000", result); end
    endtask

    task automatic test_k0();
        int cyc;
        accept(16'h00C8, 5'd16);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL k0_in_ready got=%b exp=0", in_ready); end
        wait_valid(cyc);
        tests++;
        if (cyc != 1) begin fails++; $display("FAIL k0_latency got=%0d exp=1", cyc); end
        tests++;
        if (result !== 32'h000000C8) begin fails++; $display("FAIL k0_result got=%h exp=000000c8", result); end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin fails++; $display("FAIL k0_back_idle got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        tests++;
        if (result !== 32'h000000C8) begin fails++; $display("FAIL k0_result_hold got=%h exp=000000c8", result); end
    endtask

    task automatic test_k16();
        int cyc;
        accept(16'h1234, 5'd0);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
        begin fails++; $display("FAIL k16_shift_flags got ov=%b ir=%b exp ov=0 ir=0", out_valid, in_ready); end
        wait_valid(cyc);
        tests++;
        if (cyc != lat(16)) begin fails++; $display("FAIL k16_latency got=%0d exp=%0d", cyc, lat(16)); end
        tests++;
        if (result !== 32'h12340000) begin fails++; $display("FAIL k16_result got=%h exp=12340000", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int cyc;
        out_ready = 1'b0;
        accept(16'h0003, 5'd13);
        wait_valid(cyc);
        tests++;
        if (cyc != lat(3)) begin fails++; $display("FAIL stall_latency got=%0d exp=%0d", cyc, lat(3)); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (result !== 32'h00000018 || out_valid !== 1'b1 || in_ready !== 1'b0)
            begin
                fails++;
                $display("FAIL stall_hold cyc=%0d got res=%h ov=%b ir=%b exp res=00000018 ov=1 ir=0",
                         i, result, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin fails++; $display("FAIL stall_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_clamp();
        int cyc;
        accept(16'h00FF, 5'd20);
        wait_valid(cyc);
        tests++;
        if (cyc != 1) begin fails++; $display("FAIL clamp_latency got=%0d exp=1", cyc); end
        tests++;
        if (result !== 32'h000000FF) begin fails++; $display("FAIL clamp_result got=%h exp=000000ff", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_mant();
        int cyc;
        accept(16'h0000, 5'd0);
        wait_valid(cyc);
        tests++;
        if (cyc != 1) begin fails++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
        tests++;
        if (result !== 32'h0) begin fails++; $display("FAIL zero_result got=%h exp=00000000", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int cyc;
        accept(16'hFFFF, 5'd4);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0)
        begin
            fails++;
            $display("FAIL midrst_state got ir=%b ov=%b res=%h exp ir=1 ov=0 res=00000000",
                     in_ready, out_valid, result);
        end
        accept(16'hFFFF, 5'd4);
        wait_valid(cyc);
        tests++;
        if (cyc != lat(12)) begin fails++; $display("FAIL midrst_latency got=%0d exp=%0d", cyc, lat(12)); end
        tests++;
        if (result !== 32'h0FFFF000) begin fails++; $display("FAIL midrst_result got=%h exp=0ffff000", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        accept(16'h00A5, 5'd10);
        wait_valid(cyc);
        tests++;
        if (cyc != lat(6) || result !== 32'h00002940)
        begin fails++; $display("FAIL b2b_first got lat=%0d res=%h exp lat=%0d res=00002940", cyc, result, lat(6)); end
        accept(16'h8001, 5'd15);
        wait_valid(cyc);
        tests++;
        if (cyc != lat(1) || result !== 32'h00010002)
        begin fails++; $display("FAIL b2b_second got lat=%0d res=%h exp lat=%0d res=00010002", cyc, result, lat(1)); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mant      = '0;
        shamt     = '0;
        test_reset();
        test_k0();
        test_k16();
        test_stall();
        test_clamp();
        test_zero_mant();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/approx_product_expander.md
# approx_product_expander

Back-end stage of the approximate multiplier. It receives the compact product: the 16-bit mantissa product of the two normalised top bytes, plus the total normalisation shift count applied to both operands. It rebuilds the 32-bit integer result by shifting the mantissa left by `16 - shamt`, one position per cycle, through a shift register driven by a down-counter. Valid/ready handshakes sit on both sides so it can be placed directly behind the normaliser/multiplier path.

## Interface
Parameters:
- `MANT_W`, default 16: mantissa width. Result width is `2*MANT_W`.
- `SH_W`, default 5: shift-count width. Must hold values up to `MANT_W`.

Ports:
- `clk`, in, 1: clock. One clock domain, rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `in_valid`, in, 1: `mant` and `shamt` are valid.
- `in_ready`, out, 1: block can accept a new input.
- `mant`, in, MANT_W: mantissa product.
- `shamt`, in, SH_W: total normalisation shifts (operand 1 + operand 2).
- `out_valid`, out, 1: `result` is valid.
- `out_ready`, in, 1: downstream accepts `result`.
- `result`, out, 2*MANT_W: reconstructed product. Registered.

## Operation
- Shift distance: `k = MANT_W - min(shamt, MANT_W)`, range 0..16. `shamt` values above 16 clamp to 16, giving k=0.
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
    - On `in_valid` with `in_ready`, load `result = {16'b0, mant}` and load the counter with k.
    - If k==0 or `mant`==0, go to DONE. Otherwise go to SHIFT.
  - SHIFT: each cycle, `result <= result << 1` with a zero shifted into the LSB, and counter decrements by 1.
    - When the counter reaches 0 (the shift of the last position happens in that cycle), go to DONE.
    - `in_ready`=0 and `out_valid`=0 throughout SHIFT.
  - DONE: `out_valid`=1 and `result` is held stable.
    - On `out_valid` with `out_ready`, go to IDLE.
    - `in_ready`=0 in DONE. There is no same-cycle accept-through.
- Inputs are sampled only on the accept cycle. Later changes on `mant`/`shamt` have no effect.
- No overflow is possible: the maximum value is `mant << 16`, which fits in 32 bits.
- After the output handshake, `result` keeps its last value until the next accept.
- Reset values: state=IDLE, `result`=0, counter=0, `in_ready`=1, `out_valid`=0.
- Reset asserted in any state, including mid-SHIFT, returns to IDLE on the next edge. The partial result is discarded and cleared to 0.

## Timing
- Accept at edge E0.
- With k>0 and `mant`≠0: shift edges are E1..Ek, and `out_valid` is high after Ek. Latency is k+1 cycles from the accept cycle.
- With k==0 or `mant`==0: `out_valid` is high after E0 (1 cycle).
- Minimum initiation interval is latency + 1 cycle, because one cycle is spent in IDLE after the output handshake.
- `out_ready` held low stalls in DONE indefinitely, with outputs stable.

## Configuration
- Macro: `EXPANDER_DUAL_SHIFT_EN`.
- Defined:
  - In SHIFT, when the counter is ≥2, shift by 2 and decrement by 2. Otherwise shift by 1.
  - Shift edges become `ceil(k/2)`, so latency is `ceil(k/2)+1` cycles.
  - `result` values are identical to the single-shift build.
- Undefined: single-position shift only, as described above.

## Test plan
- Reset check: assert `rst` for 2 cycles. Expect `in_ready`=1, `out_valid`=0, `result`=0x00000000.
- `mant`=0x00C8, `shamt`=16 (k=0). Expect `result`=0x000000C8 and `out_valid` 1 cycle after accept.
- `mant`=0x1234, `shamt`=0 (k=16). Expect `result`=0x12340000 with `out_valid` after 17 cycles (9 with `EXPANDER_DUAL_SHIFT_EN`).
- `mant`=0x0003, `shamt`=13 (k=3), with `out_ready` held low 5 cycles. Expect `result`=0x00000018 held stable, `in_ready`=0 during the stall, and IDLE 1 cycle after `out_ready` rises.
- `shamt`=20 with `mant`=0x00FF clamps to k=0: expect 0x000000FF in 1 cycle. `mant`=0 with `shamt`=0: expect `result`=0 in 1 cycle, with no SHIFT cycles.
- `mant`=0xFFFF, `shamt`=4 (k=12), with `rst` pulsed during the 5th SHIFT cycle. Expect IDLE, `result`=0 and `out_valid`=0 on the next edge, then a fresh transaction completes with the correct value.
